// File: rtl/transaction_pkg.sv
// rtl/transaction_pkg.sv - shared transaction-layer widths, types and destination decode
package transaction_pkg;

    localparam int NUM_PORTS = 4;
    localparam int WORD_SIZE = 10;
    localparam int DEST_W    = 2;

    typedef logic [WORD_SIZE-1:0] word_t;
    typedef logic [NUM_PORTS-1:0] port_mask_t;
    typedef logic [DEST_W-1:0]    port_idx_t;

    // Destination output FIFO lives in the two MSBs of every word.
    function automatic port_idx_t dest_of(input word_t word);
        return word[WORD_SIZE-1 -: DEST_W];
    endfunction

    function automatic port_mask_t idx_to_onehot(input port_idx_t idx);
        port_mask_t mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/transaction_arbiter_if.sv
// rtl/transaction_arbiter_if.sv - FIFO-side bus of the transaction arbiter
interface transaction_arbiter_if;
    import transaction_pkg::*;

    logic       enable;
    port_mask_t fifo_in_empty;
    word_t      fifo_in_data0;
    word_t      fifo_in_data1;
    word_t      fifo_in_data2;
    word_t      fifo_in_data3;
    port_mask_t pop_fifo_in;
    port_mask_t fifo_out_almost_full;
    port_mask_t push_fifo_out;
    word_t      data_out;

    // Arbiter side.
    modport master (
        input  enable,
        input  fifo_in_empty,
        input  fifo_in_data0,
        input  fifo_in_data1,
        input  fifo_in_data2,
        input  fifo_in_data3,
        input  fifo_out_almost_full,
        output pop_fifo_in,
        output push_fifo_out,
        output data_out
    );

    // FIFO / control side.
    modport slave (
        output enable,
        output fifo_in_empty,
        output fifo_in_data0,
        output fifo_in_data1,
        output fifo_in_data2,
        output fifo_in_data3,
        output fifo_out_almost_full,
        input  pop_fifo_in,
        input  push_fifo_out,
        input  data_out
    );

endinterface

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick starting at ptr
module rr_priority_picker
    import transaction_pkg::*;
(
    input  port_mask_t req,
    input  port_idx_t  ptr,
    output port_mask_t grant_onehot,
    output port_idx_t  grant_idx,
    output logic       grant_valid
);

    // Scan ptr, ptr+1, ... (2-bit wrap) and take the first requester.
    always_comb begin
        port_idx_t cand;
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        cand         = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = ptr + port_idx_t'(k);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_valid) begin
            grant_onehot = idx_to_onehot(grant_idx);
        end
    end

endmodule

// File: rtl/transaction_arbiter.sv
// rtl/transaction_arbiter.sv - round-robin pop of input FIFOs, routed push to output FIFOs
module transaction_arbiter
    import transaction_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_L,
    transaction_arbiter_if.master bus
);

    port_idx_t  rr_ptr;
    port_idx_t  sel_q;
    logic       v1_q;
    port_mask_t push_q;
    word_t      data_q;

    logic       stall;
    port_mask_t req;
    port_mask_t grant_onehot;
    port_idx_t  grant_idx;
    logic       grant_valid;
    word_t      sel_word;

    // Any almost-full output or an inactive control FSM blocks new pops;
    // the almost-full margin absorbs the two words already in flight.
    assign stall = !bus.enable || (|bus.fifo_out_almost_full);
    assign req   = stall ? '0 : ~bus.fifo_in_empty;

    rr_priority_picker u_picker (
        .req          (req),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid)
    );

    assign bus.pop_fifo_in = reset_L ? grant_onehot : '0;

    // Priority moves just past the last real grant; no grant leaves it alone.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= grant_idx + port_idx_t'(1);
        end
    end

    // Stage 1: remember which FIFO was popped; its data appears next cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sel_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            sel_q <= grant_idx;
            v1_q  <= grant_valid;
        end
    end

    // Read-data mux for the FIFO popped last cycle.
    always_comb begin
        sel_word = bus.fifo_in_data0;
        case (sel_q)
            2'd0: sel_word = bus.fifo_in_data0;
            2'd1: sel_word = bus.fifo_in_data1;
            2'd2: sel_word = bus.fifo_in_data2;
            2'd3: sel_word = bus.fifo_in_data3;
            default: sel_word = bus.fifo_in_data0;
        endcase
    end

    // Stage 2: register the word and push it to the FIFO named by its MSBs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_q <= '0;
            data_q <= '0;
        end else if (v1_q) begin
            push_q <= idx_to_onehot(dest_of(sel_word));
            data_q <= sel_word;
        end else begin
            push_q <= '0;
        end
    end

    assign bus.push_fifo_out = push_q;
    assign bus.data_out      = data_q;

endmodule

// File: tb/tb_transaction_arbiter.sv
// tb/tb_transaction_arbiter.sv - self-checking bench for transaction_arbiter
module tb_transaction_arbiter;
    import transaction_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_L;

    transaction_arbiter_if bus ();

    transaction_arbiter dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    // Input FIFO contents and their registered read ports.
    word_t      q [NUM_PORTS][$];
    word_t      rd [NUM_PORTS];
    port_mask_t empt;

    assign bus.fifo_in_data0 = rd[0];
    assign bus.fifo_in_data1 = rd[1];
    assign bus.fifo_in_data2 = rd[2];
    assign bus.fifo_in_data3 = rd[3];
    assign bus.fifo_in_empty = empt;

    // Reference model state.
    int         m_ptr;
    logic       m_v1;
    word_t      m_w1;
    port_mask_t m_push;
    word_t      m_data;
    word_t      sb [NUM_PORTS][$];
    logic       e_valid;
    int         e_idx;
    port_mask_t dut_pop;

    // Per-cycle logs for directed checks.
    port_mask_t pop_log[$];
    port_mask_t push_log[$];
    word_t      dat_log[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NUM_PORTS; i++) empt[i] = (q[i].size() == 0);
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_v1   = 1'b0;
        m_w1   = '0;
        m_push = '0;
        m_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) sb[i].delete();
    endtask

    task automatic compute_exp();
        e_valid = 1'b0;
        e_idx   = 0;
        if (reset_L && bus.enable && bus.fifo_out_almost_full == '0) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                int j;
                j = (m_ptr + k) % NUM_PORTS;
                if (!e_valid && q[j].size() > 0) begin
                    e_valid = 1'b1;
                    e_idx   = j;
                end
            end
        end
    endtask

    task automatic check_cycle();
        port_mask_t exp_pop;
        int jd;
        compute_exp();
        exp_pop = e_valid ? port_mask_t'(1 << e_idx) : '0;
        chk("pop", bus.pop_fifo_in, exp_pop);
        chk("push", bus.push_fifo_out, m_push);
        chk("data", bus.data_out, m_data);
        if (bus.push_fifo_out != '0) begin
            chk("push_onehot", $countones(bus.push_fifo_out), 1);
            jd = 0;
            for (int j = 0; j < NUM_PORTS; j++) if (bus.push_fifo_out[j]) jd = j;
            chk("sb_avail", sb[jd].size() != 0, 1);
            if (sb[jd].size() != 0) chk("sb_word", bus.data_out, sb[jd].pop_front());
        end
        pop_log.push_back(bus.pop_fifo_in);
        push_log.push_back(bus.push_fifo_out);
        dat_log.push_back(bus.data_out);
        dut_pop = bus.pop_fifo_in;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (reset_L) begin
            if (m_v1) begin
                m_push = idx_to_onehot(dest_of(m_w1));
                m_data = m_w1;
            end else begin
                m_push = '0;
            end
            m_v1 = e_valid;
            if (e_valid) begin
                m_w1 = q[e_idx][0];
                sb[dest_of(m_w1)].push_back(m_w1);
                m_ptr = (e_idx + 1) % NUM_PORTS;
            end
        end else begin
            model_reset();
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (dut_pop[i] && q[i].size() > 0) rd[i] = q[i].pop_front();
        end
        refresh();
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        advance();
    endtask

    task automatic clear_logs();
        pop_log.delete();
        push_log.delete();
        dat_log.delete();
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < NUM_PORTS; i++)
            for (int k = 0; k < n; k++)
                q[i].push_back({2'((i + k) % 4), 8'(8'h11 * (i + 1) + k)});
        refresh();
    endtask

    task automatic drain();
        int busy;
        busy = 1;
        for (int c = 0; c < 200 && busy != 0; c++) begin
            step();
            busy = 0;
            for (int i = 0; i < NUM_PORTS; i++) busy += q[i].size();
        end
        chk("drain", busy, 0);
        repeat (3) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int added;
        int left;
        reset_L = 1'b0;
        bus.enable = 1'b1;
        bus.fifo_out_almost_full = '0;
        for (int i = 0; i < NUM_PORTS; i++) rd[i] = '0;
        dut_pop = '0;
        model_reset();
        fill(6);
        repeat (3) step();
        chk("rst_push", push_log[2], 0);
        chk("rst_data", dat_log[2], 0);
        chk("rst_pop", pop_log[2], 0);

        // Round-robin rotation out of reset, first push two cycles after first pop.
        reset_L = 1'b1;
        clear_logs();
        repeat (5) step();
        chk("rr_pop0", pop_log[0], 4'b0001);
        chk("rr_pop1", pop_log[1], 4'b0010);
        chk("rr_pop2", pop_log[2], 4'b0100);
        chk("rr_pop3", pop_log[3], 4'b1000);
        chk("rr_pop4", pop_log[4], 4'b0001);
        chk("lat_push1", push_log[1], 4'b0000);
        chk("lat_push2", push_log[2], 4'b0001);
        chk("lat_data2", dat_log[2], 10'h011);
        chk("lat_push3", push_log[3], 4'b0010);
        chk("lat_data3", dat_log[3], 10'h122);
        drain();

        // Single non-empty input routed by destination bits.
        q[2].push_back(10'h278);
        q[2].push_back(10'h399);
        refresh();
        clear_logs();
        repeat (5) step();
        chk("one_pop0", pop_log[0], 4'b0100);
        chk("one_pop1", pop_log[1], 4'b0100);
        chk("one_push2", push_log[2], 4'b0100);
        chk("one_data2", dat_log[2], 10'h278);
        chk("one_push3", push_log[3], 4'b1000);
        chk("one_data3", dat_log[3], 10'h399);
        chk("one_ptr", dut.rr_ptr, 3);
        chk("one_mptr", m_ptr, 3);
        drain();

        // Almost-full stall for five cycles.
        fill(10);
        repeat (2) step();
        bus.fifo_out_almost_full = 4'b0001;
        clear_logs();
        repeat (5) step();
        bus.fifo_out_almost_full = '0;
        step();
        cnt = 0;
        for (int c = 0; c < 5; c++) cnt += (pop_log[c] != 0);
        chk("af_pops", cnt, 0);
        cnt = 0;
        for (int c = 0; c < 5; c++) cnt += (push_log[c] != 0);
        chk("af_pushes", cnt, 2);
        chk("af_late_push", push_log[2] | push_log[3] | push_log[4], 0);
        chk("af_resume", pop_log[5], 4'b0010);

        // Control FSM inactive.
        bus.enable = 1'b0;
        clear_logs();
        repeat (6) step();
        bus.enable = 1'b1;
        step();
        cnt = 0;
        for (int c = 0; c < 6; c++) cnt += (pop_log[c] != 0);
        chk("en_pops", cnt, 0);
        chk("en_late_push", push_log[2] | push_log[3] | push_log[4] | push_log[5], 0);
        chk("en_resume", pop_log[6], 4'b0100);

        // Reset mid-stream with both stages loaded.
        repeat (3) step();
        reset_L = 1'b0;
        model_reset();
        #1;
        chk("mid_push", bus.push_fifo_out, 0);
        chk("mid_data", bus.data_out, 0);
        chk("mid_ptr", dut.rr_ptr, 0);
        chk("mid_pop", bus.pop_fifo_in, 0);
        step();
        reset_L = 1'b1;
        clear_logs();
        repeat (3) step();
        chk("post_push0", push_log[0], 0);
        chk("post_push1", push_log[1], 0);
        chk("post_pop0", pop_log[0], 4'b0001);

        // Random traffic: 500 words with sporadic stalls.
        added = 0;
        left  = 1;
        for (int c = 0; c < 4000 && (added < 500 || left != 0); c++) begin
            for (int r = 0; r < 2; r++) begin
                if (added < 500 && $urandom_range(0, 3) != 0) begin
                    q[$urandom_range(0, 3)].push_back({2'($urandom_range(0, 3)), 8'(added)});
                    added++;
                end
            end
            refresh();
            bus.fifo_out_almost_full = ($urandom_range(0, 9) == 0) ? port_mask_t'(1 << $urandom_range(0, 3)) : '0;
            bus.enable = ($urandom_range(0, 19) != 0);
            step();
            left = 0;
            for (int i = 0; i < NUM_PORTS; i++) left += q[i].size();
        end
        bus.enable = 1'b1;
        bus.fifo_out_almost_full = '0;
        repeat (5) step();
        chk("rand_added", added, 500);
        chk("rand_left", left, 0);
        cnt = 0;
        for (int i = 0; i < NUM_PORTS; i++) cnt += sb[i].size();
        chk("rand_undelivered", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
